// File: rtl/mips16_pkg.sv
// Shared constants and types for the 16-bit multicycle MIPS memory subsystem.
package mips16_pkg;

  localparam int MIPS16_AW      = 6;
  localparam int MIPS16_DW      = 16;
  localparam int MIPS16_MEM_LAT = 1;

  // Arbiter sequencing states: decide, strobe memory, wait for data, acknowledge.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts how many consecutive arbitrations the debug port has lost to the CPU.
// Flags "starved" once the count reaches MAX so the debug port wins next time.
module arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_decide,
  input  logic i_dbg_req,
  input  logic i_dbg_win,
  output logic o_starved
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] r_cnt;

  // Clear when debug is idle or wins at a decision point, else count CPU wins up to MAX.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_decide) begin
      if (!i_dbg_req || i_dbg_win) begin
        r_cnt <= '0;
      end else if (r_cnt != CW'(MAX)) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_starved = (r_cnt == CW'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port program/data memory between the CPU datapath and the
// debug/loader port. Each access runs IDLE -> ACCESS -> WAIT(MEM_LAT) -> RESP,
// so reads and writes have the same fixed latency.
//
// Handshake: a requester holds req/we/addr/wdata stable until the cycle its ack
// is 1; req&ack completes the transaction, and req still high in the following
// cycle starts a new one. Only the current owner ever sees ack.
module mem_port_arbiter
  import mips16_pkg::*;
#(
  parameter int AW           = MIPS16_AW,
  parameter int DW           = MIPS16_DW,
  parameter int MEM_LAT      = MIPS16_MEM_LAT,
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner_dbg,
  output arb_state_t    fsm_state
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_t    r_state;
  logic [LW-1:0] r_lat;
  logic          r_we;
  logic          r_owner_dbg;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_re;
  logic          r_mem_we;
  logic          r_cpu_ack;
  logic          r_dbg_ack;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_dbg_rdata;

  logic          w_decide;
  logic          w_starved;
  logic          w_dbg_win;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  // CPU has priority unless the debug port has lost DBG_MAX_WAIT times in a row.
  assign w_decide    = (r_state == ST_IDLE);
  assign w_dbg_win   = dbg_req & (~cpu_req | w_starved);
  assign w_sel_we    = w_dbg_win ? dbg_we    : cpu_we;
  assign w_sel_addr  = w_dbg_win ? dbg_addr  : cpu_addr;
  assign w_sel_wdata = w_dbg_win ? dbg_wdata : cpu_wdata;

  arb_starve_ctr #(
    .MAX (DBG_MAX_WAIT)
  ) u_starve (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_decide  (w_decide),
    .i_dbg_req (dbg_req),
    .i_dbg_win (w_dbg_win),
    .o_starved (w_starved)
  );

  // Transaction sequencer with registered strobes, acks and read-data capture.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_lat       <= '0;
      r_we        <= 1'b0;
      r_owner_dbg <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_dbg_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_mem_re  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_dbg_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cpu_req || dbg_req) begin
            r_owner_dbg <= w_dbg_win;
            r_we        <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_re    <= ~w_sel_we;
            r_mem_we    <= w_sel_we;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_lat   <= LW'(MEM_LAT - 1);
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_lat == '0) begin
            if (!r_we) begin
              if (r_owner_dbg) begin
                r_dbg_rdata <= mem_rdata;
              end else begin
                r_cpu_rdata <= mem_rdata;
              end
            end
            r_cpu_ack <= ~r_owner_dbg;
            r_dbg_ack <= r_owner_dbg;
            r_state   <= ST_RESP;
          end else begin
            r_lat <= r_lat - LW'(1);
          end
        end
        ST_RESP: begin
          r_owner_dbg <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_ack   = r_cpu_ack;
  assign dbg_ack   = r_dbg_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;
  assign cpu_stall = cpu_req & ~r_cpu_ack;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign owner_dbg = r_owner_dbg;
  assign fsm_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a latency-accurate memory model, per-port drivers,
// and a transaction-level reference model that predicts grant order, strobe
// cycles, ack cycles and returned data from the arbitration rules.
module tb_mem_port_arbiter;
  import mips16_pkg::*;

  localparam int AW   = 6;
  localparam int DW   = 16;
  localparam int LAT1 = 1;
  localparam int LAT3 = 3;
  localparam int MAXW = 2;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    gap;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  int   cyc = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT (MEM_LAT=1) ----------------
  logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_ack;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_re, mem_we, owner_dbg;
  arb_state_t    fsm_state;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT1), .DBG_MAX_WAIT(MAXW)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .owner_dbg(owner_dbg), .fsm_state(fsm_state)
  );

  // ---------------- DUT (MEM_LAT=3) ----------------
  logic          l3_cpu_req, l3_cpu_we, l3_cpu_ack, l3_cpu_stall;
  logic [AW-1:0] l3_cpu_addr;
  logic [DW-1:0] l3_cpu_wdata, l3_cpu_rdata;
  logic          l3_dbg_req, l3_dbg_we, l3_dbg_ack;
  logic [AW-1:0] l3_dbg_addr;
  logic [DW-1:0] l3_dbg_wdata, l3_dbg_rdata;
  logic [AW-1:0] l3_mem_addr;
  logic [DW-1:0] l3_mem_wdata, l3_mem_rdata;
  logic          l3_mem_re, l3_mem_we, l3_owner_dbg;
  arb_state_t    l3_fsm_state;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT3), .DBG_MAX_WAIT(MAXW)) u_dut3 (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(l3_cpu_req), .cpu_we(l3_cpu_we), .cpu_addr(l3_cpu_addr), .cpu_wdata(l3_cpu_wdata),
    .cpu_ack(l3_cpu_ack), .cpu_rdata(l3_cpu_rdata), .cpu_stall(l3_cpu_stall),
    .dbg_req(l3_dbg_req), .dbg_we(l3_dbg_we), .dbg_addr(l3_dbg_addr), .dbg_wdata(l3_dbg_wdata),
    .dbg_ack(l3_dbg_ack), .dbg_rdata(l3_dbg_rdata),
    .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata), .mem_re(l3_mem_re), .mem_we(l3_mem_we),
    .mem_rdata(l3_mem_rdata), .owner_dbg(l3_owner_dbg), .fsm_state(l3_fsm_state)
  );

  // ---------------- memory models: data valid only LAT cycles after strobe ----------------
  logic [DW-1:0] mem1 [64];
  logic [DW-1:0] mem3 [64];
  logic [AW-1:0] p1_addr [LAT1];
  logic          p1_vld  [LAT1];
  logic [AW-1:0] p3_addr [LAT3];
  logic          p3_vld  [LAT3];

  always @(posedge clock) begin
    if (mem_we) mem1[mem_addr] = mem_wdata;
    p1_addr[0] <= mem_addr;
    p1_vld[0]  <= mem_re;
    for (int i = 1; i < LAT1; i++) begin
      p1_addr[i] <= p1_addr[i-1];
      p1_vld[i]  <= p1_vld[i-1];
    end
  end
  assign mem_rdata = p1_vld[LAT1-1] ? mem1[p1_addr[LAT1-1]] : 16'hDEAD;

  always @(posedge clock) begin
    if (l3_mem_we) mem3[l3_mem_addr] = l3_mem_wdata;
    p3_addr[0] <= l3_mem_addr;
    p3_vld[0]  <= l3_mem_re;
    for (int j = 1; j < LAT3; j++) begin
      p3_addr[j] <= p3_addr[j-1];
      p3_vld[j]  <= p3_vld[j-1];
    end
  end
  assign l3_mem_rdata = p3_vld[LAT3-1] ? mem3[p3_addr[LAT3-1]] : 16'hBEEF;

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " cpu_ack"},   64'(cpu_ack),   64'd0);
    chk({tag, " dbg_ack"},   64'(dbg_ack),   64'd0);
    chk({tag, " mem_re"},    64'(mem_re),    64'd0);
    chk({tag, " mem_we"},    64'(mem_we),    64'd0);
    chk({tag, " owner_dbg"}, 64'(owner_dbg), 64'd0);
    chk({tag, " cpu_rdata"}, 64'(cpu_rdata), 64'd0);
    chk({tag, " dbg_rdata"}, 64'(dbg_rdata), 64'd0);
    chk({tag, " mem_addr"},  64'(mem_addr),  64'd0);
    chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, " state"},     64'(fsm_state), 64'(ST_IDLE));
  endtask

  // ---------------- reference model ----------------
  txn_t          cpu_q[$];
  txn_t          dbg_q[$];
  logic [48:0]   exp_q[$];   // {owner_dbg, ack cycle, rdata}
  logic [55:0]   strb_q[$];  // {owner_dbg, we, addr, wdata, strobe cycle}
  logic [DW-1:0] sh_mem [64];
  logic [DW-1:0] m_cpu_rd = '0;
  logic [DW-1:0] m_dbg_rd = '0;

  function automatic txn_t mk(input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [3:0] g);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d; t.gap = g;
    return t;
  endfunction

  // Walks decision points in time: each grant occupies LAT1+3 cycles; a port's
  // next request appears `gap` cycles after its ack.
  task automatic model_run(input int s);
    int   ci, di, c_arr, d_arr, d, cnt, ack;
    logic cp, dp, wd;
    txn_t t;
    logic [DW-1:0] rd;
    ci = 0; di = 0; cnt = 0; d = s;
    c_arr = (cpu_q.size() > 0) ? s + int'(cpu_q[0].gap) : 0;
    d_arr = (dbg_q.size() > 0) ? s + int'(dbg_q[0].gap) : 0;
    while (ci < cpu_q.size() || di < dbg_q.size()) begin
      cp = (ci < cpu_q.size()) && (c_arr <= d);
      dp = (di < dbg_q.size()) && (d_arr <= d);
      if (!cp && !dp) begin
        d   = d + 1;
        cnt = 0;
      end else begin
        wd = dp && (!cp || cnt == MAXW);
        if (dp && !wd) cnt = (cnt < MAXW) ? cnt + 1 : MAXW;
        else           cnt = 0;
        t = wd ? dbg_q[di] : cpu_q[ci];
        strb_q.push_back({wd, t.we, t.addr, t.wdata, 32'(d + 1)});
        if (t.we)    sh_mem[t.addr] = t.wdata;
        else if (wd) m_dbg_rd = sh_mem[t.addr];
        else         m_cpu_rd = sh_mem[t.addr];
        rd  = wd ? m_dbg_rd : m_cpu_rd;
        ack = d + 2 + LAT1;
        exp_q.push_back({wd, 32'(ack), rd});
        if (wd) begin
          di++;
          if (di < dbg_q.size()) d_arr = ack + int'(dbg_q[di].gap);
        end else begin
          ci++;
          if (ci < cpu_q.size()) c_arr = ack + int'(cpu_q[ci].gap);
        end
        d = ack + 1;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_cpu();
    logic got;
    for (int i = 0; i < cpu_q.size(); i++) begin
      if (cpu_q[i].gap != 0) begin
        cpu_req = 1'b0;
        repeat (int'(cpu_q[i].gap)) @(negedge clock);
      end
      cpu_we = cpu_q[i].we; cpu_addr = cpu_q[i].addr; cpu_wdata = cpu_q[i].wdata;
      cpu_req = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 64 && !got; k++) begin
        @(negedge clock);
        if (cpu_ack) got = 1'b1;
      end
      chk("cpu ack within budget", 64'(got), 64'd1);
      if (!got) break;
    end
    cpu_req = 1'b0;
  endtask

  task automatic drive_dbg();
    logic got;
    for (int i = 0; i < dbg_q.size(); i++) begin
      if (dbg_q[i].gap != 0) begin
        dbg_req = 1'b0;
        repeat (int'(dbg_q[i].gap)) @(negedge clock);
      end
      dbg_we = dbg_q[i].we; dbg_addr = dbg_q[i].addr; dbg_wdata = dbg_q[i].wdata;
      dbg_req = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 64 && !got; k++) begin
        @(negedge clock);
        if (dbg_ack) got = 1'b1;
      end
      chk("dbg ack within budget", 64'(got), 64'd1);
      if (!got) break;
    end
    dbg_req = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic        mon_en = 1'b0;
  logic [48:0] mon_e;
  logic [55:0] mon_s;

  always @(negedge clock) begin
    if (mon_en) begin
      if (cpu_ack || dbg_ack) begin
        chk("acks exclusive", 64'(cpu_ack && dbg_ack), 64'd0);
        chk("ack expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("ack owner", 64'(dbg_ack), 64'(mon_e[48]));
          chk("ack cycle", 64'(cyc), 64'(mon_e[47:16]));
          chk("ack rdata", 64'(dbg_ack ? dbg_rdata : cpu_rdata), 64'(mon_e[15:0]));
          chk("owner_dbg at ack", 64'(owner_dbg), 64'(mon_e[48]));
        end
      end
      if (mem_re || mem_we) begin
        chk("strobe expected", 64'(strb_q.size() > 0), 64'd1);
        if (strb_q.size() > 0) begin
          mon_s = strb_q.pop_front();
          chk("strobe re", 64'(mem_re), 64'(!mon_s[54]));
          chk("strobe we", 64'(mem_we), 64'(mon_s[54]));
          chk("strobe addr", 64'(mem_addr), 64'(mon_s[53:48]));
          chk("strobe wdata", 64'(mem_wdata), 64'(mon_s[47:32]));
          chk("strobe cycle", 64'(cyc), 64'(mon_s[31:0]));
          chk("owner_dbg at strobe", 64'(owner_dbg), 64'(mon_s[55]));
        end
      end
    end
  end

  task automatic run_phase(input string tag);
    int s;
    @(negedge clock);
    s = cyc;
    model_run(s);
    mon_en = 1'b1;
    fork
      drive_cpu();
      drive_dbg();
    join
    repeat (4) @(negedge clock);
    mon_en = 1'b0;
    chk({tag, " acks outstanding"},    64'(exp_q.size()),  64'd0);
    chk({tag, " strobes outstanding"}, 64'(strb_q.size()), 64'd0);
    exp_q.delete();
    strb_q.delete();
  endtask

  task automatic rand_lists();
    int nc, nd;
    cpu_q.delete();
    dbg_q.delete();
    nc = $urandom_range(2, 5);
    nd = $urandom_range(1, 4);
    for (int i = 0; i < nc; i++)
      cpu_q.push_back(mk(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                         16'($urandom), 4'($urandom_range(0, 3))));
    for (int i = 0; i < nd; i++)
      dbg_q.push_back(mk(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                         16'($urandom), 4'($urandom_range(0, 3))));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    l3_cpu_req = 1'b0; l3_cpu_we = 1'b0; l3_cpu_addr = '0; l3_cpu_wdata = '0;
    l3_dbg_req = 1'b0; l3_dbg_we = 1'b0; l3_dbg_addr = '0; l3_dbg_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      mem1[i]   = 16'($urandom);
      sh_mem[i] = mem1[i];
      mem3[i]   = 16'($urandom);
    end
    mem1[5] = 16'hA1B2; sh_mem[5] = 16'hA1B2;
    mem3[9] = 16'h5A5A;

    // Reset values
    repeat (3) @(negedge clock);
    chk_reset("reset");
    chk("reset l3 cpu_rdata", 64'(l3_cpu_rdata), 64'd0);
    chk("reset l3 state", 64'(l3_fsm_state), 64'(ST_IDLE));
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // CPU read alone
    cpu_q.delete(); dbg_q.delete();
    cpu_q.push_back(mk(1'b0, 6'h05, 16'h0000, 4'd0));
    run_phase("cpu_rd");
    chk("cpu_rd data", 64'(cpu_rdata), 64'h0000_0000_0000_A1B2);

    // Debug write then CPU read of the same address
    cpu_q.delete(); dbg_q.delete();
    dbg_q.push_back(mk(1'b1, 6'h0F, 16'h1234, 4'd0));
    cpu_q.push_back(mk(1'b0, 6'h0F, 16'h0000, 4'd2));
    run_phase("dbg_wr_cpu_rd");
    chk("dbg_wr_cpu_rd data", 64'(cpu_rdata), 64'h0000_0000_0000_1234);
    chk("dbg_wr_cpu_rd dbg_rdata kept", 64'(dbg_rdata), 64'd0);

    // Contention: expected grants CPU, CPU, DBG, CPU
    cpu_q.delete(); dbg_q.delete();
    for (int i = 0; i < 4; i++) cpu_q.push_back(mk(1'b0, 6'(20 + i), 16'h0, 4'd0));
    dbg_q.push_back(mk(1'b0, 6'h30, 16'h0, 4'd0));
    run_phase("contention");

    // Back-to-back CPU reads 0,1,2
    cpu_q.delete(); dbg_q.delete();
    for (int i = 0; i < 3; i++) cpu_q.push_back(mk(1'b0, 6'(i), 16'h0, 4'd0));
    run_phase("b2b");

    // Reset during WAIT of a CPU read, then reissue
    @(negedge clock);
    cpu_we = 1'b0; cpu_addr = 6'h07; cpu_wdata = '0; cpu_req = 1'b1;
    @(negedge clock);
    chk("rst_mid strobe", 64'(mem_re), 64'd1);
    @(negedge clock);
    chk("rst_mid in wait", 64'(fsm_state), 64'(ST_WAIT));
    chk("rst_mid stall", 64'(cpu_stall), 64'd1);
    reset_n = 1'b0;
    @(negedge clock);
    chk_reset("rst_mid");
    reset_n = 1'b1;
    m_cpu_rd = sh_mem[7];
    m_dbg_rd = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      chk($sformatf("reissue cpu_ack k=%0d", k), 64'(cpu_ack), 64'(k == 3));
      chk($sformatf("reissue dbg_ack k=%0d", k), 64'(dbg_ack), 64'd0);
      if (k == 3) begin
        chk("reissue data", 64'(cpu_rdata), 64'(m_cpu_rd));
        chk("reissue stall on ack", 64'(cpu_stall), 64'd0);
        cpu_req = 1'b0;
      end
    end
    repeat (3) @(negedge clock);

    // Random mixed traffic
    for (int r = 0; r < 8; r++) begin
      rand_lists();
      run_phase($sformatf("rand%0d", r));
    end

    // MEM_LAT=3 single read: strobe at t+1, ack at t+5
    @(negedge clock);
    l3_cpu_we = 1'b0; l3_cpu_addr = 6'h09; l3_cpu_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      chk($sformatf("lat3 mem_re k=%0d", k), 64'(l3_mem_re), 64'(k == 1));
      chk($sformatf("lat3 ack k=%0d", k), 64'(l3_cpu_ack), 64'(k == 5));
      if (l3_cpu_ack) l3_cpu_req = 1'b0;
    end
    chk("lat3 rdata", 64'(l3_cpu_rdata), 64'h0000_0000_0000_5A5A);
    l3_cpu_req = 1'b0;

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-port program/data memory (Memoria) of the 16-bit multicycle MIPS core between two requesters: the CPU datapath (instruction fetch and load/store) and a debug/loader port driven from the board switches and keys. It sequences each access through a fixed issue/wait/response pipeline. It returns read data and a one-cycle acknowledge to the winning requester. CPU has priority, with a bounded-starvation guarantee for the debug port. It sits between the top-level datapath (mux_PC address path, MDR/IR capture) and the memory instance.

## Interface
Parameters:
- AW, 6: memory address width (64 words).
- DW, 16: data width.
- MEM_LAT, 1: memory read latency in cycles after the strobe cycle (≥1).
- DBG_MAX_WAIT, 4: number of lost arbitrations after which the debug port wins the next one (≥1).

Ports:
- clock, in, 1: single clock; all state updates on rising edge.
- reset_n, in, 1: synchronous, active-low reset.
- cpu_req / cpu_we, in, 1 / 1: CPU request valid / write (1) or read (0).
- cpu_addr / cpu_wdata, in, AW / DW: CPU address / write data.
- cpu_ack, out, 1: one-cycle pulse; CPU transaction complete.
- cpu_rdata, out, DW: CPU read data, valid when cpu_ack=1 and held afterwards.
- cpu_stall, out, 1: cpu_req & ~cpu_ack (combinational); gates the control FSM.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: same meanings as the CPU equivalents, for the debug port.
- mem_addr / mem_wdata, out, AW / DW: memory address / write data.
- mem_re / mem_we, out, 1 / 1: memory read / write strobes.
- mem_rdata, in, DW: memory read data, valid MEM_LAT cycles after the mem_re cycle.
- owner_dbg, out, 1: 1 while a debug transaction is in flight.

## Operation
- Handshake rules:
  - Requester holds req, we, addr and wdata stable until the cycle in which its ack is 1.
  - The transaction completes on req&ack.
  - req still high in the cycle after ack is a new transaction.
- States:
  - IDLE: decision point. If no request, stay. Otherwise latch the winner's we/addr/wdata and owner, then go to ACCESS.
  - ACCESS: drive mem_addr, mem_wdata and mem_re=~we / mem_we=we for exactly one cycle, then go to WAIT.
  - WAIT: MEM_LAT cycles (down-counter). On the last WAIT cycle, capture mem_rdata into the owner's rdata register for reads only. Then go to RESP.
  - RESP: pulse the owner's ack for one cycle, then go to IDLE.
- Arbitration at IDLE:
  - Only one request: it wins.
  - Both requesting: CPU wins unless starve_cnt == DBG_MAX_WAIT, in which case debug wins.
- starve_cnt:
  - Increments when CPU wins while dbg_req=1.
  - Clears when debug wins or when dbg_req=0 at a decision point.
  - Saturates at DBG_MAX_WAIT.
- Writes traverse the same states, giving uniform latency, and leave rdata unchanged.
- Outside ACCESS:
  - mem_re = mem_we = 0.
  - mem_addr and mem_wdata hold their last latched values.
- The non-owner's ack is always 0. A request arriving mid-transaction waits for the next IDLE.

## Timing
- Request seen at IDLE in cycle t:
  - ACCESS at t+1.
  - WAIT over t+2..t+1+MEM_LAT.
  - ack at t+2+MEM_LAT, i.e. t+3 for MEM_LAT=1.
- Back-to-back throughput: one transaction per MEM_LAT+3 cycles.
- Reset values (reset_n=0 at an edge):
  - state=IDLE.
  - All strobes, acks and owner_dbg = 0.
  - cpu_rdata = dbg_rdata = 0.
  - mem_addr = mem_wdata = 0.
  - starve_cnt = 0.
- Reset mid-transaction aborts it with no ack. The requester reissues after reset deasserts.
- Address wrap: none. Addresses are passed through unmodified; AW bits index the full memory.

## Structure
- Shared package mips16_pkg:
  - AW/DW constants.
  - State encoding constants ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESP.
  - MEM_LAT default.
- Sub-module arb_starve_ctr (increment/clear/saturate; outputs a starved flag).
- The top module instantiates it and contains the FSM, latency counter, latches and rdata registers.

## Test plan
- CPU read alone: cpu_req=1, addr=0x05, memory word 5 = 0xA1B2 → mem_re=1 exactly at t+1, cpu_ack at t+3, cpu_rdata=0xA1B2, dbg_ack=0.
- Debug write then CPU read of the same address: dbg write 0x0F←0x1234, then cpu read 0x0F → dbg_ack at t+3, cpu_rdata=0x1234, and dbg_rdata unchanged.
- Contention with DBG_MAX_WAIT=2: both req held continuously, CPU re-requesting after each ack → grant order CPU, CPU, DBG, CPU…; owner_dbg high only during the third transaction.
- Back-to-back CPU reads 0x00,0x01,0x02 with req held → acks exactly 4 cycles apart (MEM_LAT=1) with correct data for each.
- Reset during WAIT of a CPU read → no cpu_ack, all outputs at reset values next cycle, starve_cnt=0; the reissued read completes normally.
- MEM_LAT=3 build: single read → ack at t+5 with data captured from the third post-strobe cycle.
